// File: rtl/bus_arb.sv
// bus_arb: single-port memory bus arbiter and stall sequencer for the
// five-stage eriscv pipeline.
//
// The fetch path (pc_reg/if_id) and the load/store path (mem stage) share
// one external memory bus. Only one transaction is outstanding at a time.
// Load/store normally wins arbitration. A waiting fetch that has lost
// MAX_WAIT arbitrations in a row wins the next one.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   if_req_i/if_addr_i  fetch request and address
//   flush_i             discard any in-flight fetch response
//   if_gnt_o            fetch address phase accepted
//   if_rvalid_o         fetch data valid (one-cycle pulse)
//   if_rdata_o          fetch data (0 when not valid)
//   mem_*_i             load/store request, write enable, byte enables,
//                       address and write data
//   mem_gnt_o           load/store address phase accepted
//   mem_rvalid_o        load/store response valid
//   mem_rdata_o         load data (0 when not valid)
//   bus_*_o             registered bus request, write enable, byte enables,
//                       address and write data
//   bus_gnt_i           bus accepted the address phase
//   bus_rvalid_i        bus response valid
//   bus_rdata_i         bus read data
//   stall_o             pipeline stall: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
module bus_arb #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [5:0]  stall_o
);

  localparam int unsigned   CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    REQ_IF,
    REQ_MEM,
    WAIT_IF,
    WAIT_MEM
  } state_t;

  state_t          state;
  logic [CW-1:0]   starve_cnt;
  logic            discard;
  logic            fetch_wins;
  logic            mem_wins;
  logic            if_rv;
  logic            mem_rv;

  // Arbitration decision, only acted upon in IDLE.
  always_comb begin
    fetch_wins = if_req_i && (!mem_req_i || (starve_cnt == CNT_MAX));
    mem_wins   = mem_req_i && !fetch_wins;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      discard     <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_wins) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_be_o    <= '1;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            starve_cnt  <= '0;
            state       <= REQ_IF;
          end else if (mem_wins) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_be_o    <= mem_be_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
            // Count only arbitrations a waiting fetch actually lost.
            if (if_req_i && (starve_cnt != CNT_MAX)) begin
              starve_cnt <= starve_cnt + CW'(1);
            end
            state <= REQ_MEM;
          end
        end
        REQ_IF: begin
          if (flush_i) begin
            discard <= 1'b1;
          end
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= WAIT_IF;
          end
        end
        REQ_MEM: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= WAIT_MEM;
          end
        end
        WAIT_IF: begin
          // Clearing on return to IDLE takes priority over a late flush.
          if (bus_rvalid_i) begin
            discard <= 1'b0;
            state   <= IDLE;
          end else if (flush_i) begin
            discard <= 1'b1;
          end
        end
        WAIT_MEM: begin
          if (bus_rvalid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants and responses are same-cycle pass-throughs of the bus handshake,
  // qualified by the owning state.
  always_comb begin
    if_gnt_o     = (state == REQ_IF) && bus_gnt_i;
    mem_gnt_o    = (state == REQ_MEM) && bus_gnt_i;
    if_rv        = (state == WAIT_IF) && bus_rvalid_i && !flush_i && !discard;
    mem_rv       = (state == WAIT_MEM) && bus_rvalid_i;
    if_rvalid_o  = if_rv;
    mem_rvalid_o = mem_rv;
    if_rdata_o   = if_rv ? bus_rdata_i : '0;
    mem_rdata_o  = mem_rv ? bus_rdata_i : '0;
  end

  always_comb begin
    stall_o = '0;
    if (mem_req_i && !mem_rv) begin
      stall_o = 6'b011111;
    end else if (if_req_i && !if_rv && !flush_i) begin
      stall_o = 6'b000011;
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
module tb_bus_arb;

  localparam int unsigned MW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic [5:0]  stall;

  always #5 clk = ~clk;

  bus_arb #(.MAX_WAIT(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .flush_i      (flush),
    .if_gnt_o     (if_gnt),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .mem_req_i    (mem_req),
    .mem_we_i     (mem_we),
    .mem_be_i     (mem_be),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .mem_gnt_o    (mem_gnt),
    .mem_rvalid_o (mem_rvalid),
    .mem_rdata_o  (mem_rdata),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_be_o     (bus_be),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .bus_gnt_i    (bus_gnt),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata),
    .stall_o      (stall)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  // Reference: how many arbitrations in a row a waiting fetch has lost.
  int unsigned losses      = 0;
  bit          last_fetch_won;
  bit          obs_mem_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] stall_ref(bit mr, bit mrv, bit ir, bit irv, bit fl);
    if (mr && !mrv) return 6'b011111;
    if (ir && !irv && !fl) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk_bus_zero(input string tag);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_bus_fields"}, {bus_we, bus_be}, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
  endtask

  // One idle cycle with no requests and random stray bus handshakes.
  task automatic idle_cycle();
    bus_gnt    = 1'($urandom_range(0, 1));
    bus_rvalid = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom;
    flush      = 1'($urandom_range(0, 1));
    settle();
    chk("idle_bus_req", bus_req, 0);
    chk("idle_gnt", {if_gnt, mem_gnt}, 0);
    chk("idle_rvalid", {if_rvalid, mem_rvalid}, 0);
    chk("idle_rdata", if_rdata | mem_rdata, 0);
    chk("idle_stall", stall, stall_ref(mem_req, 0, if_req, 0, flush));
    tick();
    bus_gnt = 0; bus_rvalid = 0; flush = 0;
  endtask

  // One full transaction starting from IDLE with the current request inputs.
  // gw/rw: wait cycles before grant/response; flush_at: cycle index counted
  // from the first REQ cycle at which flush_i pulses (-1 for none).
  task automatic txn(input int gw, input int rw, input int flush_at, input logic [31:0] rdata);
    bit fw, mwin, disc, erv_if, erv_mem;
    logic [31:0] e_addr, e_wdata;
    logic [4:0]  e_webe;
    int idx;
    fw      = if_req && (!mem_req || losses == MW);
    mwin    = mem_req && !fw;
    e_addr  = mwin ? mem_addr : if_addr;
    e_wdata = mwin ? mem_wdata : 32'h0;
    e_webe  = mwin ? {mem_we, mem_be} : 5'b0_1111;
    bus_gnt = 0; bus_rvalid = 0; flush = 0; bus_rdata = $urandom;
    settle();
    chk("arb_bus_req", bus_req, 0);
    chk("arb_gnt", {if_gnt, mem_gnt}, 0);
    chk("arb_rvalid", {if_rvalid, mem_rvalid}, 0);
    chk("arb_stall", stall, stall_ref(mem_req, 0, if_req, 0, 0));
    if (fw) losses = 0;
    else if (if_req && losses < MW) losses++;
    last_fetch_won = fw;
    disc = 0;
    idx  = 0;
    tick();
    for (int k = 0; k <= gw; k++) begin
      bus_gnt    = (k == gw);
      bus_rvalid = ($urandom_range(0, 3) == 0);
      bus_rdata  = $urandom;
      flush      = (idx == flush_at);
      if (fw && flush) disc = 1;
      settle();
      chk("req_bus_req", bus_req, 1);
      chk("req_addr", bus_addr, e_addr);
      chk("req_wdata", bus_wdata, e_wdata);
      chk("req_we_be", {bus_we, bus_be}, e_webe);
      chk("req_gnt", {if_gnt, mem_gnt}, {fw && k == gw, mwin && k == gw});
      chk("req_rvalid", {if_rvalid, mem_rvalid}, 0);
      chk("req_stall", stall, stall_ref(mem_req, 0, if_req, 0, flush));
      if (k == gw) obs_mem_gnt = mem_gnt;
      idx++;
      tick();
    end
    for (int k = 0; k <= rw; k++) begin
      bus_gnt    = ($urandom_range(0, 3) == 0);
      bus_rvalid = (k == rw);
      bus_rdata  = (k == rw) ? rdata : $urandom;
      flush      = (idx == flush_at);
      if (fw && flush) disc = 1;
      erv_if  = fw && (k == rw) && !disc;
      erv_mem = mwin && (k == rw);
      settle();
      chk("wait_bus_req", bus_req, 0);
      chk("wait_gnt", {if_gnt, mem_gnt}, 0);
      chk("wait_rvalid", {if_rvalid, mem_rvalid}, {erv_if, erv_mem});
      chk("wait_if_rdata", if_rdata, erv_if ? rdata : 32'h0);
      chk("wait_mem_rdata", mem_rdata, erv_mem ? rdata : 32'h0);
      chk("wait_stall", stall, stall_ref(mem_req, erv_mem, if_req, erv_if, flush));
      idx++;
      tick();
    end
    bus_gnt = 0; bus_rvalid = 0; flush = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [5:0] order;
    int gw, rw, fa;
    // Reset with both requests high.
    rst = 0; if_req = 1; mem_req = 1; flush = 0;
    if_addr = 32'h40; mem_we = 0; mem_be = 4'hF; mem_addr = 32'h200; mem_wdata = 32'h5;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 32'hA5A5_A5A5;
    tick();
    settle();
    chk_bus_zero("rst");
    chk("rst_gnt", {if_gnt, mem_gnt}, 0);
    chk("rst_rvalid", {if_rvalid, mem_rvalid}, 0);
    chk("rst_rdata", if_rdata | mem_rdata, 0);
    chk("rst_stall", stall, 6'b011111);
    tick();

    // Release with a single fetch, zero-wait bus.
    rst = 1; mem_req = 0; if_req = 1; if_addr = 32'h0000_0010;
    txn(0, 0, -1, 32'h0000_0013);
    chk("first_fetch_winner", last_fetch_won, 1);

    // Store with grant delayed three cycles.
    if_req = 0; mem_req = 1; mem_we = 1; mem_be = 4'b0011;
    mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    txn(3, 0, -1, 32'h0);
    mem_req = 0; mem_we = 0;

    // Both requesting continuously: mem, mem, if, mem, mem, if.
    if_req = 1; mem_req = 1; if_addr = 32'h80; mem_addr = 32'h300; mem_be = 4'hF;
    order = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      txn(0, 0, -1, $urandom);
      chk("starve_order", obs_mem_gnt, order[i]);
    end

    // Flush in WAIT_IF before the response, then a normal fetch.
    mem_req = 0; if_req = 1; if_addr = 32'h1000;
    txn(1, 2, 2, 32'h1111_2222);
    if_addr = 32'h2000;
    txn(0, 0, -1, 32'h3333_4444);
    // Flush in REQ_IF.
    txn(0, 1, 0, 32'h5555_6666);
    // Flush during a load has no effect.
    if_req = 0; mem_req = 1; mem_we = 0; mem_addr = 32'h400;
    txn(1, 1, 1, 32'h7777_8888);

    // Reset while in WAIT_MEM, then a late response.
    mem_addr = 32'h500;
    tick();              // IDLE: sampled
    bus_gnt = 1; tick(); // REQ_MEM: granted
    bus_gnt = 0; rst = 0;
    settle();
    chk_bus_zero("midrst");
    chk("midrst_rvalid", {if_rvalid, mem_rvalid}, 0);
    chk("midrst_stall", stall, 6'b011111);
    tick();
    rst = 1; mem_req = 0; bus_rvalid = 1; bus_rdata = 32'hBAD0_BAD0;
    settle();
    chk("postrst_mem_rvalid", mem_rvalid, 0);
    chk("postrst_mem_rdata", mem_rdata, 0);
    chk_bus_zero("postrst");
    tick();
    bus_rvalid = 0;
    losses = 0;

    // Stray handshakes in IDLE, then a normal transaction.
    for (int i = 0; i < 3; i++) idle_cycle();
    mem_req = 1; mem_we = 1; mem_be = 4'b1000; mem_addr = 32'h600; mem_wdata = 32'h1234_5678;
    txn(0, 1, -1, 32'h0);
    mem_req = 0;

    // Randomized traffic; a losing requester keeps its request pending.
    if_req = 0; mem_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (!if_req || last_fetch_won) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!mem_req || !last_fetch_won) begin
        mem_req   = 1'($urandom_range(0, 1));
        mem_we    = 1'($urandom_range(0, 1));
        mem_be    = 4'($urandom_range(0, 15));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
      if (!if_req && !mem_req) begin
        idle_cycle();
        last_fetch_won = 1;
      end else begin
        gw = $urandom_range(0, 3);
        rw = $urandom_range(0, 3);
        fa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, gw + rw + 1)) : -1;
        txn(gw, rw, fa, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
